// File: rtl/sort_drain.sv
`default_nettype none
// ============================================================================
// Module     : sort_drain
// Description: Reads `size` sorted 32-bit words out of sorter memory and
//              presents them on a valid/ready stream with a last flag.
//              Optional signed ordering monitor: SORT_DRAIN_ORDER_CHECK_EN.
// Revision   : 1.0
// ============================================================================
module sort_drain #(
   parameter int size = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   output logic                      rd_en,
   output logic [$clog2(size):0]     rd_addr,
   input  logic [31:0]               sorted_in,
   output logic [31:0]               out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      out_last,
   output logic                      busy,
   output logic                      drain_done,
   output logic                      order_err
);

   localparam int size_addr = $clog2(size);
   localparam logic [size_addr:0] c_last_idx = (size_addr+1)'(size - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      FIN  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [size_addr:0]   r_idx;
   logic [size_addr:0]   w_next_idx;
   logic [31:0]          r_out_data;
   logic                 w_accept_start;
   logic                 w_is_last;

   assign w_accept_start = (r_state == IDLE) && start;
   assign w_is_last      = (r_idx == c_last_idx);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_out_data <= '0;
      end else begin
         r_state <= w_next_state;
         r_idx   <= w_next_idx;
         if (r_state == WAIT) begin
            r_out_data <= sorted_in;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_idx   = r_idx;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_idx   = '0;
               w_next_state = READ;
            end
         end
         READ: w_next_state = WAIT;
         WAIT: w_next_state = SEND;
         SEND: begin
            if (out_ready) begin
               if (w_is_last) begin
                  w_next_state = FIN;
               end else begin
                  w_next_idx   = r_idx + 1'b1;
                  w_next_state = READ;
               end
            end
         end
         FIN:     w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // All handshake outputs decode straight from the state register.
   assign rd_en      = (r_state == READ);
   assign rd_addr    = r_idx;
   assign out_data   = r_out_data;
   assign out_valid  = (r_state == SEND);
   assign out_last   = (r_state == SEND) && w_is_last;
   assign busy       = (r_state != IDLE);
   assign drain_done = (r_state == FIN);

`ifdef SORT_DRAIN_ORDER_CHECK_EN
   logic r_order_err;

   // r_out_data still holds the previously sent word while WAIT captures the next.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_order_err <= 1'b0;
      end else if (w_accept_start) begin
         r_order_err <= 1'b0;
      end else if ((r_state == WAIT) && (r_idx != '0) &&
                   ($signed(r_out_data) > $signed(sorted_in))) begin
         r_order_err <= 1'b1;
      end
   end

   assign order_err = r_order_err;
`else
   logic w_unused_accept;
   assign w_unused_accept = w_accept_start;
   assign order_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_drain.sv
`default_nettype none
// ============================================================================
// Module     : tb_sort_drain
// Description: Self-checking bench for sort_drain (table vectors + random runs
//              against a word-sequence reference model).
// Revision   : 1.0
// ============================================================================
module tb_sort_drain;

   localparam int size = 8;
`ifdef SORT_DRAIN_ORDER_CHECK_EN
   localparam bit ORDER_EN = 1'b1;
`else
   localparam bit ORDER_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [31:0] sorted_in;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        drain_done;
   logic        order_err;

   int checks = 0;
   int errors = 0;
   bit exp_err = 1'b0;

   logic signed [31:0] mem [8];

   sort_drain #(.size(size)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .sorted_in  (sorted_in),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .drain_done (drain_done),
      .order_err  (order_err)
   );

   always #5 clk = ~clk;

   // Sorter memory: one-cycle read latency, garbage when not read.
   always @(posedge clk) begin
      if (rd_en) sorted_in <= mem[rd_addr[2:0]];
      else       sorted_in <= $urandom;
   end

   typedef struct {
      logic signed [31:0] data [8];
      int stall_word;
      int stall_len;
      int glitch_word;
      int exp_cycles;
      bit exp_err_en;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"},      rd_en,      0);
      check({tag, "_rd_addr"},    rd_addr,    0);
      check({tag, "_out_data"},   out_data,   0);
      check({tag, "_out_valid"},  out_valid,  0);
      check({tag, "_out_last"},   out_last,   0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_drain_done"}, drain_done, 0);
      check({tag, "_order_err"},  order_err,  0);
   endtask

   // Runs one full drain of mem[] and checks the stream against the model:
   // words appear in address order, one read per word, 25 cycles plus stalls.
   task automatic run_drain(input int stall_word, input int stall_len, input int glitch_word,
                            input bit rand_ready, input int exp_cycles);
      int c, w, stalls, rds, stall_cnt, hold_cnt, first_seen;
      bit done;
      logic [31:0] exp_word;
      c = 0; w = 0; stalls = 0; rds = 0; stall_cnt = 0; hold_cnt = 0;
      first_seen = -1; done = 1'b0;
      check("idle_before_start", busy, 0);
      check("err_before_start", order_err, exp_err);
      start = 1'b1;
      tick();
      start   = 1'b0;
      exp_err = 1'b0;
      c = 1;
      check("rd_en_at_t1", rd_en, 1);
      while (!done && c < 400) begin
         start = 1'b0;
         if (rd_en) begin
            check("rd_addr", rd_addr, w);
            rds++;
         end
         if (out_valid) begin
            if (first_seen != w) begin
               first_seen = w;
               if (w > 0 && w < size && mem[w-1] > mem[w]) exp_err = ORDER_EN;
               if (w == glitch_word) start = 1'b1;
            end
            exp_word = (w < size) ? mem[w] : 32'hDEAD_BEEF;
            check("out_data", out_data, exp_word);
            check("out_last", out_last, (w == size - 1));
            if (w == stall_word) hold_cnt++;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else            out_ready = !(w == stall_word && stall_cnt < stall_len);
            if (out_ready) w++;
            else begin
               stalls++;
               stall_cnt++;
            end
         end else begin
            check("out_last_invalid", out_last, 0);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         check("order_err", order_err, exp_err);
         if (drain_done) begin
            done = 1'b1;
            check("done_cycles", c, (exp_cycles < 0) ? 25 + stalls : exp_cycles);
            check("word_count", w, size);
            check("read_count", rds, size);
            check("busy_fin", busy, 1);
         end else begin
            check("busy_run", busy, 1);
         end
         tick();
         c++;
      end
      check("drain_timeout", done, 1);
      start     = 1'b0;
      out_ready = 1'b0;
      if (!rand_ready && stall_len > 0) check("stall_hold", hold_cnt, stall_len + 1);
      check("busy_after", busy, 0);
      check("done_pulse", drain_done, 0);
      check("valid_after", out_valid, 0);
   endtask

   initial begin
      vecs[0] = '{'{-5, -1, 0, 2, 3, 7, 9, 100}, -1, 0, -1, 25, 1'b0};
      vecs[1] = '{'{-5, -1, 0, 2, 3, 7, 9, 100},  2, 4, -1, 29, 1'b0};
      vecs[2] = '{'{ 1,  2, 5, 4, 6, 7, 8,   9}, -1, 0, -1, 25, 1'b1};
      vecs[3] = '{'{-5, -1, 0, 2, 3, 7, 9, 100}, -1, 0,  1, 25, 1'b0};
      vecs[4] = '{'{ 8,  7, 6, 5, 4, 3, 2,   1}, -1, 0,  5, 25, 1'b1};

      rstn = 1'b0; start = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < size; i++) mem[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rstn = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < size; i++) mem[i] = vecs[v].data[i];
         run_drain(vecs[v].stall_word, vecs[v].stall_len, vecs[v].glitch_word, 1'b0,
                   vecs[v].exp_cycles);
         check("final_err", order_err, ORDER_EN & vecs[v].exp_err_en);
         tick();
      end

      // Reset during WAIT of word 5 after an ordering violation was flagged.
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < size; i++) mem[i] = vecs[2].data[i];
         out_ready = 1'b1;
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int k = 0; k < 40 && !found; k++) begin
            if (rd_en && rd_addr == 4'd4) found = 1'b1;
            else tick();
         end
         check("reach_word5", found, 1);
         tick();
         check("err_before_reset", order_err, ORDER_EN);
         check("busy_before_reset", busy, 1);
         rstn = 1'b0;
         #1;
         check_all_zero("midreset");
         exp_err = 1'b0;
         @(negedge clk);
         rstn = 1'b1;
         out_ready = 1'b0;
         repeat (3) tick();
         check("no_resume", busy, 0);
         check("no_resume_rd", rd_en, 0);
         for (int i = 0; i < size; i++) mem[i] = vecs[0].data[i];
         run_drain(-1, 0, -1, 1'b0, 25);
      end

      // Random data and random back-pressure.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < size; i++) begin
            if (r % 2 == 0) mem[i] = $urandom;
            else            mem[i] = $signed($urandom_range(0, 20)) - 10;
         end
         if (r % 3 != 0) begin
            for (int i = 1; i < size; i++)
               for (int j = i; j > 0 && mem[j-1] > mem[j]; j--) begin
                  logic signed [31:0] t;
                  t = mem[j]; mem[j] = mem[j-1]; mem[j-1] = t;
               end
         end
         run_drain(-1, 0, int'($urandom_range(0, 7)), 1'b1, -1);
         repeat (int'($urandom_range(0, 3))) tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
